rle_block_assembler: RTL

- Converts the entropy decoder's (run, value) coefficient symbols into one complete 64-entry quantized block in zigzag order.
- Output format is the flat zigzag vector (`Q-bit signed, index 0 = DC) consumed by the inverse-zigzag / dequantization path.
- Sits directly between the Huffman/RLE symbol decoder and the zigzag-reordering stage.
- Single block buffer; valid/ready handshakes on both sides.

---
 rtl/rle_block_assembler_pkg.sv | 15 +
 rtl/rle_block_assembler.sv | 91 +++++++++
 2 files changed

// File: rtl/rle_block_assembler_pkg.sv
// Shared constants and state type for the RLE block assembler.
package rle_block_assembler_pkg;

  localparam int unsigned Q     = 16;  // default signed coefficient width
  localparam int unsigned RunW  = 4;   // default zero-run field width
  localparam int unsigned BlkN  = 64;  // coefficients per block
  localparam int unsigned IdxW  = 6;   // index into a block
  localparam int unsigned PosW  = 7;   // idx + run, wide enough to see overflow

  typedef enum logic {
    StFill,
    StDone
  } state_e;

endpackage

// File: rtl/rle_block_assembler.sv
// Assembles (run, value) symbols into one zigzag-ordered 64-coefficient block.
module rle_block_assembler
  import rle_block_assembler_pkg::*;
#(
  parameter int unsigned DATA_W = Q,
  parameter int unsigned RUN_W  = RunW
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic                           sym_valid_i,
  output logic                           sym_ready_o,
  input  logic [RUN_W-1:0]               sym_run_i,
  input  logic [DATA_W-1:0]              sym_value_i,
  input  logic                           sym_eob_i,
  output logic                           blk_valid_o,
  input  logic                           blk_ready_i,
  output logic [BlkN-1:0][DATA_W-1:0]    blk_zz_o,
  output logic                           blk_err_o
);

  state_e                       state_q, state_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic [BlkN-1:0][DATA_W-1:0]  coef_q, coef_d;
  logic                         err_q, err_d;
  logic [PosW-1:0]              pos;

  // Target position of the incoming value; bit 6 set means it fell off the block.
  assign pos = PosW'(idx_q) + PosW'(sym_run_i);

  // Next-state: place values while filling, clear everything on block handoff.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    coef_d  = coef_q;
    err_d   = err_q;
    unique case (state_q)
      StFill: begin
        if (sym_valid_i) begin
          if (sym_eob_i) begin
            err_d   = 1'b0;
            state_d = StDone;
          end else if (pos < PosW'(BlkN - 1)) begin
            coef_d[pos[IdxW-1:0]] = sym_value_i;
            idx_d                 = pos[IdxW-1:0] + IdxW'(1);
          end else if (pos == PosW'(BlkN - 1)) begin
            coef_d[BlkN-1] = sym_value_i;
            err_d          = 1'b0;
            state_d        = StDone;
          end else begin
            // Overflow: drop the value and flag the block as broken.
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (blk_ready_i) begin
          coef_d  = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StFill;
      idx_q   <= '0;
      coef_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      coef_q  <= coef_d;
      err_q   <= err_d;
    end
  end

  // Outputs follow the state directly.
  always_comb begin
    sym_ready_o = (state_q == StFill);
    blk_valid_o = (state_q == StDone);
    blk_zz_o    = coef_q;
    blk_err_o   = err_q;
  end

endmodule
